// File: rtl/mem_req_arbiter_if.sv
// Bundle of ifetch, LSB and MemCtrl signals around the memory request arbiter.
// The arbiter connects through the slave modport; the surrounding logic uses master.
interface mem_req_arbiter_if #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LINE_BYTES = 4
);
    localparam int unsigned LINE_W = 8 * LINE_BYTES;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [LINE_W-1:0] if_data;

    logic              ls_req;
    logic              ls_rw;
    logic [ADDR_W-1:0] ls_addr;
    logic [2:0]        ls_len;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_done;
    logic [DATA_W-1:0] ls_rdata;

    logic              mc_en;
    logic              mc_is_if;
    logic              mc_rw;
    logic [ADDR_W-1:0] mc_addr;
    logic [7:0]        mc_len;
    logic [DATA_W-1:0] mc_wdata;
    logic              mc_done;
    logic [LINE_W-1:0] mc_if_data;
    logic [DATA_W-1:0] mc_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_done, if_data,
        input  ls_req, ls_rw, ls_addr, ls_len, ls_wdata,
        output ls_done, ls_rdata,
        output mc_en, mc_is_if, mc_rw, mc_addr, mc_len, mc_wdata,
        input  mc_done, mc_if_data, mc_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_done, if_data,
        output ls_req, ls_rw, ls_addr, ls_len, ls_wdata,
        input  ls_done, ls_rdata,
        input  mc_en, mc_is_if, mc_rw, mc_addr, mc_len, mc_wdata,
        output mc_done, mc_if_data, mc_rdata
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Single-outstanding arbiter sharing MemCtrl between ifetch and the LSB:
// stores first, fetch anti-starvation, speculative reads squashed on rollback.
module mem_req_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LINE_BYTES = 4,
    parameter int unsigned STARVE_MAX = 4
) (
    input logic              clk,
    input logic              rst,
    input logic              rdy,
    input logic              rollback,
    mem_req_arbiter_if.slave bus
);
    localparam int unsigned LINE_W   = 8 * LINE_BYTES;
    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DRAIN = 2'd2,
        S_GAP   = 2'd3
    } state_e;

    state_e              state_q,    state_d;
    logic [STARVE_W-1:0] starve_q,   starve_d;
    logic                mc_en_q,    mc_en_d;
    logic                mc_is_if_q, mc_is_if_d;
    logic                mc_rw_q,    mc_rw_d;
    logic [ADDR_W-1:0]   mc_addr_q,  mc_addr_d;
    logic [7:0]          mc_len_q,   mc_len_d;
    logic [DATA_W-1:0]   mc_wdata_q, mc_wdata_d;
    logic                if_done_q,  if_done_d;
    logic [LINE_W-1:0]   if_data_q,  if_data_d;
    logic                ls_done_q,  ls_done_d;
    logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;
    logic                grant_if_c, grant_ls_c;

    // Next-state, grant and completion logic; everything holds while rdy is low.
    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        mc_en_d    = mc_en_q;
        mc_is_if_d = mc_is_if_q;
        mc_rw_d    = mc_rw_q;
        mc_addr_d  = mc_addr_q;
        mc_len_d   = mc_len_q;
        mc_wdata_d = mc_wdata_q;
        if_done_d  = if_done_q;
        if_data_d  = if_data_q;
        ls_done_d  = ls_done_q;
        ls_rdata_d = ls_rdata_q;
        grant_if_c = 1'b0;
        grant_ls_c = 1'b0;

        if (rdy) begin
            if_done_d = 1'b0;
            ls_done_d = 1'b0;
            if (!bus.if_req) begin
                starve_d = '0;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (!rollback) begin
                        if (bus.ls_req && bus.ls_rw) begin
                            grant_ls_c = 1'b1;
                        end else if (bus.if_req && (starve_q >= STARVE_W'(STARVE_MAX))) begin
                            grant_if_c = 1'b1;
                        end else if (bus.ls_req) begin
                            grant_ls_c = 1'b1;
                        end else if (bus.if_req) begin
                            grant_if_c = 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    if (bus.mc_done) begin
                        mc_en_d = 1'b0;
                        state_d = S_GAP;
                        // Stores are committed and always report; reads report only if not squashed.
                        if (mc_rw_q || !rollback) begin
                            if (mc_is_if_q) begin
                                if_done_d = 1'b1;
                                if_data_d = bus.mc_if_data;
                            end else begin
                                ls_done_d = 1'b1;
                                if (!mc_rw_q) begin
                                    ls_rdata_d = bus.mc_rdata;
                                end
                            end
                        end
                    end else if (rollback && !mc_rw_q) begin
                        state_d = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (bus.mc_done) begin
                        mc_en_d = 1'b0;
                        state_d = S_GAP;
                    end
                end
                S_GAP: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            if (grant_if_c) begin
                state_d    = S_BUSY;
                mc_en_d    = 1'b1;
                mc_is_if_d = 1'b1;
                mc_rw_d    = 1'b0;
                mc_addr_d  = bus.if_addr;
                mc_len_d   = 8'(LINE_BYTES);
                starve_d   = '0;
            end

            if (grant_ls_c) begin
                state_d    = S_BUSY;
                mc_en_d    = 1'b1;
                mc_is_if_d = 1'b0;
                mc_rw_d    = bus.ls_rw;
                mc_addr_d  = bus.ls_addr;
                mc_len_d   = 8'(bus.ls_len);
                mc_wdata_d = bus.ls_wdata;
                if (bus.if_req && (starve_q < STARVE_W'(STARVE_MAX))) begin
                    starve_d = starve_q + STARVE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            starve_q   <= '0;
            mc_en_q    <= 1'b0;
            mc_is_if_q <= 1'b0;
            mc_rw_q    <= 1'b0;
            mc_addr_q  <= '0;
            mc_len_q   <= '0;
            mc_wdata_q <= '0;
            if_done_q  <= 1'b0;
            if_data_q  <= '0;
            ls_done_q  <= 1'b0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            mc_en_q    <= mc_en_d;
            mc_is_if_q <= mc_is_if_d;
            mc_rw_q    <= mc_rw_d;
            mc_addr_q  <= mc_addr_d;
            mc_len_q   <= mc_len_d;
            mc_wdata_q <= mc_wdata_d;
            if_done_q  <= if_done_d;
            if_data_q  <= if_data_d;
            ls_done_q  <= ls_done_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign bus.mc_en    = mc_en_q;
    assign bus.mc_is_if = mc_is_if_q;
    assign bus.mc_rw    = mc_rw_q;
    assign bus.mc_addr  = mc_addr_q;
    assign bus.mc_len   = mc_len_q;
    assign bus.mc_wdata = mc_wdata_q;
    assign bus.if_done  = if_done_q;
    assign bus.if_data  = if_data_q;
    assign bus.ls_done  = ls_done_q;
    assign bus.ls_rdata = ls_rdata_q;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter with a fixed-latency MemCtrl model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_req_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic rollback;

    int n_chk = 0;
    int n_bad = 0;

    int          mc_lat    = 5;
    int          mc_cnt    = 0;
    logic        mc_busy   = 1'b0;
    logic [31:0] fetch_word = 32'hDDCCBBAA;
    logic [31:0] load_word  = 32'hCAFEF00D;

    mem_req_arbiter_if bus ();

    mem_req_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .rollback (rollback),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_mc_en(input int limit);
        for (int i = 0; i < limit && !bus.mc_en; i++) @(negedge clk);
    endtask

    task automatic wait_mc_done(input int limit);
        for (int i = 0; i < limit && !bus.mc_done; i++) @(negedge clk);
    endtask

    task automatic wait_if_done(input int limit);
        for (int i = 0; i < limit && !bus.if_done; i++) @(negedge clk);
    endtask

    task automatic wait_ls_done(input int limit);
        for (int i = 0; i < limit && !bus.ls_done; i++) @(negedge clk);
    endtask

    // MemCtrl model: mc_done pulses mc_lat cycles after mc_en is first seen.
    initial begin
        bus.mc_done    = 1'b0;
        bus.mc_if_data = '0;
        bus.mc_rdata   = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                mc_busy     = 1'b0;
                bus.mc_done = 1'b0;
            end else if (bus.mc_done) begin
                bus.mc_done = 1'b0;
                mc_busy     = 1'b0;
            end else if (mc_busy) begin
                mc_cnt--;
                if (mc_cnt == 0) begin
                    bus.mc_done    = 1'b1;
                    bus.mc_if_data = fetch_word;
                    bus.mc_rdata   = load_word;
                end
            end else if (bus.mc_en) begin
                mc_busy = 1'b1;
                mc_cnt  = mc_lat;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int n_loads;
        logic got_if;
        logic seen_done;

        rst          = 1'b1;
        rdy          = 1'b1;
        rollback     = 1'b0;
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.ls_req   = 1'b0;
        bus.ls_rw    = 1'b0;
        bus.ls_addr  = '0;
        bus.ls_len   = '0;
        bus.ls_wdata = '0;
        step(2);
        check_eq("rst_mc_en",   64'(bus.mc_en),   64'd0);
        check_eq("rst_if_done", 64'(bus.if_done), 64'd0);
        check_eq("rst_ls_done", 64'(bus.ls_done), 64'd0);
        check_eq("rst_mc_addr", 64'(bus.mc_addr), 64'd0);
        rst = 1'b0;
        step(1);

        // Fetch
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        step(1);
        check_eq("f_mc_en",    64'(bus.mc_en),    64'd1);
        check_eq("f_mc_addr",  64'(bus.mc_addr),  64'h100);
        check_eq("f_mc_len",   64'(bus.mc_len),   64'd4);
        check_eq("f_mc_is_if", 64'(bus.mc_is_if), 64'd1);
        check_eq("f_mc_rw",    64'(bus.mc_rw),    64'd0);
        lat = 0;
        while (!bus.mc_done && lat < 50) begin
            step(1);
            lat++;
        end
        check_eq("f_mc_lat", 64'(lat), 64'd5);
        step(1);
        check_eq("f_if_done", 64'(bus.if_done), 64'd1);
        check_eq("f_if_data", 64'(bus.if_data), 64'hDDCCBBAA);
        check_eq("f_mc_en_lo", 64'(bus.mc_en),  64'd0);
        check_eq("f_ls_done", 64'(bus.ls_done), 64'd0);
        bus.if_req = 1'b0;
        step(1);
        check_eq("f_if_pulse", 64'(bus.if_done), 64'd0);
        step(1);

        // Reset in the middle of a busy fetch
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h300;
        step(1);
        check_eq("r_mc_en", 64'(bus.mc_en), 64'd1);
        step(2);
        rst = 1'b1;
        #1;
        check_eq("r_async_en",   64'(bus.mc_en),    64'd0);
        check_eq("r_async_addr", 64'(bus.mc_addr),  64'd0);
        check_eq("r_async_isif", 64'(bus.mc_is_if), 64'd0);
        check_eq("r_async_len",  64'(bus.mc_len),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1);
        check_eq("r_regrant",  64'(bus.mc_en),   64'd1);
        check_eq("r_reg_addr", 64'(bus.mc_addr), 64'h300);
        wait_if_done(50);
        check_eq("r_if_done", 64'(bus.if_done), 64'd1);
        bus.if_req = 1'b0;
        step(1);

        // Store and fetch contend in the same cycle
        bus.ls_req   = 1'b1;
        bus.ls_rw    = 1'b1;
        bus.ls_addr  = 32'h20;
        bus.ls_len   = 3'd4;
        bus.ls_wdata = 32'h11223344;
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h200;
        step(1);
        check_eq("c_mc_rw",    64'(bus.mc_rw),    64'd1);
        check_eq("c_mc_is_if", 64'(bus.mc_is_if), 64'd0);
        check_eq("c_mc_addr",  64'(bus.mc_addr),  64'h20);
        check_eq("c_mc_wdata", 64'(bus.mc_wdata), 64'h11223344);
        wait_ls_done(50);
        check_eq("c_ls_done", 64'(bus.ls_done), 64'd1);
        check_eq("c_if_excl", 64'(bus.if_done), 64'd0);
        bus.ls_req = 1'b0;
        step(1);
        check_eq("c_gap_en", 64'(bus.mc_en), 64'd0);
        step(1);
        check_eq("c_f_en",   64'(bus.mc_en),    64'd1);
        check_eq("c_f_isif", 64'(bus.mc_is_if), 64'd1);
        check_eq("c_f_addr", 64'(bus.mc_addr),  64'h200);
        wait_if_done(50);
        check_eq("c_if_done", 64'(bus.if_done), 64'd1);
        bus.if_req = 1'b0;
        step(1);

        // Starvation: back-to-back loads against a held fetch
        mc_lat       = 1;
        bus.ls_req   = 1'b1;
        bus.ls_rw    = 1'b0;
        bus.ls_addr  = 32'h80;
        bus.ls_len   = 3'd4;
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h400;
        n_loads      = 0;
        got_if       = 1'b0;
        for (int g = 0; g < 8 && !got_if; g++) begin
            wait_mc_en(20);
            if (bus.mc_en && bus.mc_is_if) begin
                got_if     = 1'b1;
                bus.ls_req = 1'b0;
                wait_if_done(20);
                bus.if_req = 1'b0;
            end else begin
                n_loads++;
                wait_ls_done(20);
                if (g == 0) check_eq("s_ls_rdata", 64'(bus.ls_rdata), 64'hCAFEF00D);
            end
            step(1);
        end
        check_eq("s_n_loads", 64'(n_loads), 64'd4);
        check_eq("s_got_if",  64'(got_if),  64'd1);
        bus.ls_req = 1'b0;
        bus.if_req = 1'b0;
        step(2);

        // Rollback during an in-flight load drains it silently
        mc_lat      = 5;
        bus.ls_req  = 1'b1;
        bus.ls_rw   = 1'b0;
        bus.ls_addr = 32'h40;
        bus.ls_len  = 3'd2;
        step(1);
        check_eq("l_mc_en",  64'(bus.mc_en),  64'd1);
        check_eq("l_mc_len", 64'(bus.mc_len), 64'd2);
        step(1);
        rollback    = 1'b1;
        bus.ls_req  = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h500;
        step(1);
        rollback = 1'b0;
        check_eq("l_drain_hold", 64'(bus.mc_en), 64'd1);
        seen_done = 1'b0;
        for (int i = 0; i < 50 && !bus.mc_done; i++) begin
            step(1);
            if (bus.ls_done) seen_done = 1'b1;
        end
        check_eq("l_mc_done_seen", 64'(bus.mc_done), 64'd1);
        step(1);
        check_eq("l_gap_en",   64'(bus.mc_en),   64'd0);
        check_eq("l_gap_done", 64'(bus.ls_done), 64'd0);
        step(1);
        check_eq("l_idle_en",   64'(bus.mc_en),   64'd0);
        check_eq("l_idle_done", 64'(bus.ls_done), 64'd0);
        step(1);
        check_eq("l_next_en",   64'(bus.mc_en),    64'd1);
        check_eq("l_next_isif", 64'(bus.mc_is_if), 64'd1);
        check_eq("l_no_done",   64'(seen_done),    64'd0);
        wait_if_done(50);
        bus.if_req = 1'b0;
        step(1);

        // Rollback during a store does not cancel it
        bus.ls_req   = 1'b1;
        bus.ls_rw    = 1'b1;
        bus.ls_addr  = 32'h60;
        bus.ls_len   = 3'd1;
        bus.ls_wdata = 32'hAB;
        step(1);
        check_eq("w_mc_rw", 64'(bus.mc_rw), 64'd1);
        step(1);
        rollback = 1'b1;
        step(1);
        rollback = 1'b0;
        wait_ls_done(50);
        check_eq("w_ls_done", 64'(bus.ls_done), 64'd1);
        bus.ls_req = 1'b0;
        step(2);

        // Rollback coincident with a load's mc_done squashes it
        mc_lat      = 3;
        bus.ls_req  = 1'b1;
        bus.ls_rw   = 1'b0;
        bus.ls_addr = 32'h70;
        bus.ls_len  = 3'd4;
        step(1);
        check_eq("q_mc_en", 64'(bus.mc_en), 64'd1);
        wait_mc_done(50);
        rollback   = 1'b1;
        bus.ls_req = 1'b0;
        step(1);
        rollback = 1'b0;
        check_eq("q_ls_done", 64'(bus.ls_done), 64'd0);
        check_eq("q_mc_en_lo", 64'(bus.mc_en),  64'd0);
        step(1);
        check_eq("q_ls_done2", 64'(bus.ls_done), 64'd0);
        step(1);

        // Rollback in IDLE blocks the grant; rdy low freezes
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h600;
        rollback    = 1'b1;
        step(1);
        check_eq("i_rb_nogrant", 64'(bus.mc_en), 64'd0);
        rollback = 1'b0;
        rdy      = 1'b0;
        step(2);
        check_eq("i_rdy_freeze", 64'(bus.mc_en), 64'd0);
        rdy = 1'b1;
        step(1);
        check_eq("i_rdy_grant", 64'(bus.mc_en),   64'd1);
        check_eq("i_rdy_addr",  64'(bus.mc_addr), 64'h600);
        wait_if_done(50);
        check_eq("i_if_done", 64'(bus.if_done), 64'd1);
        bus.if_req = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
